mod3_check_scheduler: RTL
=========================

# mod3_check_scheduler

Shared-resource scheduler for the bit-serial modulo-3 checker. Up to N_REQ requesters each submit a WIDTH-bit word. A round-robin arbiter grants one requester at a time, captures its word, and streams it MSB-first through a single residue FSM. The block then reports the residue, a divisible flag and the requester ID. It sits between the divisibility-test clients and the one serial mod-3 datapath, so the client side needs no per-client checker.

## Interface
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 8, word width in bits (>=2)
- clk  in  1  rising-edge clock, the only clock
- rst  in  1  asynchronous, active-high reset
- req  in  N_REQ  per-requester request level
- data  in  N_REQ*WIDTH  flattened words; slice i is data[i*WIDTH +: WIDTH]; sampled only at the grant edge
- grant  out  N_REQ  one-hot, 1-cycle pulse: the word for that ID was captured
- busy  out  1  high while in SHIFT or DONE
- done  out  1  1-cycle pulse: result valid
- done_id  out  clog2(N_REQ)  ID of the finished job
- residue  out  2  word mod 3 (0..2)
- divisible  out  1  residue==0 for the finished job

## Operation
- States: IDLE, SHIFT, DONE. Reset puts the block in IDLE.
- IDLE, at a clock edge with |req:
  - winner = first set req searching from (last_id+1) mod N_REQ upward, with wrap-around.
  - On that edge: grant<=onehot(winner), shreg<=data slice, cnt<=WIDTH, r<=0, last_id<=winner, state<=SHIFT.
- SHIFT, each edge:
  - b = shreg[WIDTH-1]; r <= (2r+b) mod 3; shreg <= shreg<<1; cnt <= cnt-1.
  - When cnt==1, the final bit is consumed and state<=DONE.
- DONE, for one cycle:
  - done=1; residue, divisible and done_id are updated on the same edge.
  - Next state is IDLE.
- residue, divisible and done_id hold their values until the next DONE.
- The residue recurrence is the S0/S1/S2 serial mod-3 machine: r=0 moves to 0 or 1, r=1 moves to 2 or 0, r=2 moves to 1 or 2, for b=0 or 1.
- req is a level. A requester drops req in the cycle grant is seen. A req still high at the next IDLE is a new job.
- req arriving during SHIFT or DONE waits. No request is lost while it is held.
- A requester's req is never ignored for more than N_REQ-1 other grants.

## Timing
- Cycle 0 is the IDLE cycle in which req is sampled.
- grant is high in cycle 1, and SHIFT occupies cycles 1..WIDTH.
- done is high in cycle WIDTH+1, and the block is back in IDLE in cycle WIDTH+2.
- Throughput is one job per WIDTH+2 cycles.
- All outputs are registered; there is no combinational path from req or data to any output.
- Reset values: grant=0, busy=0, done=0, done_id=0, residue=0, divisible=0, state=IDLE, last_id=N_REQ-1 (so requester 0 wins first).
- rst mid-job aborts immediately and asynchronously. No done pulse is issued for the aborted job, and the client must re-request.
- Simultaneous requests are resolved by the round-robin pointer only; there is no fixed priority after the first grant.

## Configuration
- LEADING_ZERO_SKIP_EN
- Defined:
  - At the grant edge, lz = leading-zero count of the word.
  - shreg <= word<<lz and cnt <= WIDTH-lz.
  - If the word is 0 (cnt=0), state goes straight to DONE with residue 0. done is then high in cycle 1, together with grant.
  - Otherwise done is high in cycle WIDTH-lz+1.
- Undefined: fixed WIDTH-cycle SHIFT regardless of data.
- Results are identical in both builds; only latency differs.

## Structure
- Shared package mod3_pkg holds:
  - the state enum {IDLE, SHIFT, DONE};
  - residue constants R0/R1/R2;
  - a function mod3_step(r,b) returning (2r+b) mod 3.
- Sub-module mod3_residue_fsm: holds r, with inputs clr, en, b and output r[1:0]. The top level holds the arbiter, shift register, counter and result registers.

## Test plan
- Single job: req[0] with 8'd9 -> grant[0] in cycle 1, done in cycle 9, residue=0, divisible=1, done_id=0.
- Residue values:
  - 8'd100 -> residue=1.
  - 8'd200 -> residue=2.
  - 8'hFF -> residue=0, divisible=1.
- All four req raised together after reset -> grants in order 0,1,2,3, spaced 10 cycles apart, with done_id matching each.
- req1 and req2 held high continuously -> grants alternate 1,2,1,2; req0 and req3 never granted.
- rst pulsed in the 4th SHIFT cycle of a job -> all outputs 0 at once, no done pulse; the next request from req0 and req3 is granted to req0.
- LEADING_ZERO_SKIP_EN:
  - With the macro: 8'd3 -> done in cycle 3, residue=0; 8'd0 -> done in cycle 1, divisible=1.
  - Without the macro: both words -> done in cycle 9.

Source files
------------

// File: rtl/mod3_pkg.sv
// mod3_pkg: scheduler states, residue encodings and the serial mod-3 step.
// Shared by mod3_residue_fsm and mod3_check_scheduler.
package mod3_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  localparam logic [1:0] R0 = 2'd0;
  localparam logic [1:0] R1 = 2'd1;
  localparam logic [1:0] R2 = 2'd2;

  // (2r + b) mod 3
  function automatic logic [1:0] mod3_step(
    input logic [1:0] r,
    input logic       b
  );
    logic [1:0] n;
    unique case (r)
      R0:      n = b ? R1 : R0;
      R1:      n = b ? R0 : R2;
      R2:      n = b ? R2 : R1;
      default: n = R0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mod3_residue_fsm.sv
// mod3_residue_fsm: S0/S1/S2 residue register fed one bit per enabled cycle.
// clr restarts the residue at zero and wins over en.
module mod3_residue_fsm
  import mod3_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       b,
  output logic [1:0] r
);

  logic [1:0] r_q;
  logic [1:0] r_d;

  always_comb begin
    r_d = r_q;
    if (clr) begin
      r_d = R0;
    end else if (en) begin
      r_d = mod3_step(r_q, b);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= R0;
    end else begin
      r_q <= r_d;
    end
  end

  assign r = r_q;

endmodule

// File: rtl/mod3_check_scheduler.sv
// mod3_check_scheduler: round-robin access to one bit-serial mod-3 checker.
// Optional LEADING_ZERO_SKIP_EN drops leading zeros to shorten SHIFT.
module mod3_check_scheduler
  import mod3_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int WIDTH = 8,
  localparam int IDW   = $clog2(N_REQ),
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] data,
  output logic [N_REQ-1:0]       grant,
  output logic                   busy,
  output logic                   done,
  output logic [IDW-1:0]         done_id,
  output logic [1:0]             residue,
  output logic                   divisible
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IDW-1:0]   last_q, last_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [IDW-1:0]   done_id_q, done_id_d;
  logic [1:0]       res_q, res_d;
  logic             div_q, div_d;

  logic             found;
  logic [IDW-1:0]   win;
  logic [IDW-1:0]   cand;
  logic [WIDTH-1:0] word;
  logic             clr;
  logic             en;
  logic             b;
  logic [1:0]       r;
  logic [1:0]       r_next;

  // Search starts just after the last winner, so no fixed priority remains.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDW'((int'(last_q) + k) % N_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign word   = data[win*WIDTH +: WIDTH];
  assign b      = shreg_q[WIDTH-1];
  assign r_next = mod3_step(r, b);

`ifdef LEADING_ZERO_SKIP_EN
  logic [CW-1:0] lz;

  always_comb begin
    lz = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (word[i]) begin
        lz = CW'(WIDTH - 1 - i);
      end
    end
  end
`endif

  mod3_residue_fsm u_fsm (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .en  (en),
    .b   (b),
    .r   (r)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    grant_d   = '0;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    res_d     = res_q;
    div_d     = div_q;
    clr       = 1'b0;
    en        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = N_REQ'(1) << win;
          last_d  = win;
          clr     = 1'b1;
          state_d = SHIFT;
`ifdef LEADING_ZERO_SKIP_EN
          shreg_d = word << lz;
          cnt_d   = CW'(WIDTH) - lz;
          // An all-zero word has nothing to shift: report at once.
          if (word == '0) begin
            state_d   = DONE;
            done_d    = 1'b1;
            done_id_d = win;
            res_d     = R0;
            div_d     = 1'b1;
          end
`else
          shreg_d = word;
          cnt_d   = CW'(WIDTH);
`endif
        end
      end
      SHIFT: begin
        en      = 1'b1;
        shreg_d = shreg_q << 1;
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d   = DONE;
          done_d    = 1'b1;
          done_id_d = last_q;
          res_d     = r_next;
          div_d     = (r_next == R0);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      cnt_q     <= '0;
      last_q    <= IDW'(N_REQ - 1);
      grant_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      res_q     <= R0;
      div_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      res_q     <= res_d;
      div_q     <= div_d;
    end
  end

  assign grant     = grant_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign done_id   = done_id_q;
  assign residue   = res_q;
  assign divisible = div_q;

endmodule
